vector_register_bank: RTL and testbench

- Parametrised vector register file: NUM_VREGS vector registers, each VECTOR_REG_DEPTH elements of VECTOR_REG_WIDTH bits.
- Provides NUM_READ_PORTS independent streaming read ports and one byte-masked element write port.
- Each read port accepts a (register, length) request and streams elements 0..len-1 under valid/ready backpressure to a functional-unit pipeline.
- Same-cycle write-to-read bypass lets the write port and the read ports operate on one register concurrently, which supports chaining.

---
 rtl/vector_register_bank.sv | 172 +++++++++++++++++
 tb/tb_vector_register_bank.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_register_bank.sv
// Vector register file with one byte-masked element write port and N streaming read ports.
// Latency: first element appears 1 cycle after request acceptance; one element per handshake after that.
// Backpressure: each read port holds rd_data/rd_last/rd_valid while rd_ready is low; writes are never stalled.
module vector_register_bank #(
  parameter int NUM_VREGS        = 8,
  parameter int VECTOR_REG_DEPTH = 64,
  parameter int VECTOR_REG_WIDTH = 64,
  parameter int NUM_READ_PORTS   = 2,
  localparam int RW = $clog2(NUM_VREGS),
  localparam int EW = $clog2(VECTOR_REG_DEPTH),
  localparam int LW = EW + 1,
  localparam int BW = VECTOR_REG_WIDTH / 8
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   wr_en,
  input  logic [RW-1:0]                          wr_vreg,
  input  logic [EW-1:0]                          wr_elem,
  input  logic [VECTOR_REG_WIDTH-1:0]            wr_data,
  input  logic [BW-1:0]                          wr_be,
  input  logic [NUM_READ_PORTS-1:0]              req_valid,
  output logic [NUM_READ_PORTS-1:0]              req_ready,
  input  logic [NUM_READ_PORTS*RW-1:0]           req_vreg,
  input  logic [NUM_READ_PORTS*LW-1:0]           req_len,
  output logic [NUM_READ_PORTS-1:0]              rd_valid,
  input  logic [NUM_READ_PORTS-1:0]              rd_ready,
  output logic [NUM_READ_PORTS*VECTOR_REG_WIDTH-1:0] rd_data,
  output logic [NUM_READ_PORTS-1:0]              rd_last,
  input  logic [NUM_READ_PORTS-1:0]              rd_abort
);

  typedef enum logic {
    ST_IDLE,
    ST_STREAM
  } rd_state_t;

  localparam logic [LW-1:0] DEPTH_L = LW'(VECTOR_REG_DEPTH);

  logic [VECTOR_REG_WIDTH-1:0] r_mem [NUM_VREGS][VECTOR_REG_DEPTH];

  // Writes to a non-existent register are dropped here and never bypass either.
  logic w_wr_ok;
  assign w_wr_ok = wr_en && (int'(wr_vreg) < NUM_VREGS);

  // Storage update: clear everything on reset, otherwise merge enabled bytes.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int v = 0; v < NUM_VREGS; v++) begin
        for (int e = 0; e < VECTOR_REG_DEPTH; e++) begin
          r_mem[v][e] <= '0;
        end
      end
    end else if (w_wr_ok) begin
      for (int b = 0; b < BW; b++) begin
        if (wr_be[b]) begin
          r_mem[wr_vreg][wr_elem][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_port
    rd_state_t                   r_state, w_state_nxt;
    logic [RW-1:0]               r_vreg, w_vreg_nxt;
    logic [LW-1:0]               r_len, w_len_nxt;
    logic [EW-1:0]               r_idx, w_idx_nxt;
    logic [VECTOR_REG_WIDTH-1:0] r_data, w_data_nxt;
    logic                        r_last, w_last_nxt;

    logic [RW-1:0]               w_req_vreg;
    logic [LW-1:0]               w_req_len;
    logic [LW-1:0]               w_eff_len;
    logic [LW-1:0]               w_idx_inc;
    logic [RW-1:0]               w_ld_vreg;
    logic [EW-1:0]               w_ld_elem;
    logic                        w_ld_vreg_ok;
    logic                        w_ld_hit;
    logic [VECTOR_REG_WIDTH-1:0] w_ld_mem;
    logic [VECTOR_REG_WIDTH-1:0] w_ld_data;

    assign w_req_vreg = req_vreg[p*RW +: RW];
    assign w_req_len  = req_len[p*LW +: LW];
    assign w_eff_len  = (w_req_len > DEPTH_L) ? DEPTH_L : w_req_len;
    assign w_idx_inc  = {1'b0, r_idx} + LW'(1);

    // The only element that can be loaded this edge: element 0 of the
    // requested register when idle, the next element when streaming.
    assign w_ld_vreg    = (r_state == ST_IDLE) ? w_req_vreg : r_vreg;
    assign w_ld_elem    = (r_state == ST_IDLE) ? '0 : w_idx_inc[EW-1:0];
    assign w_ld_vreg_ok = int'(w_ld_vreg) < NUM_VREGS;
    assign w_ld_mem     = w_ld_vreg_ok ? r_mem[w_ld_vreg][w_ld_elem] : '0;
    assign w_ld_hit     = w_wr_ok && (wr_vreg == w_ld_vreg) && (wr_elem == w_ld_elem);

    // Write-first bypass: a same-edge write to the loaded element is merged in.
    always_comb begin
      w_ld_data = w_ld_mem;
      for (int b = 0; b < BW; b++) begin
        if (w_ld_hit && wr_be[b]) begin
          w_ld_data[8*b +: 8] = wr_data[8*b +: 8];
        end
      end
    end

    // Read-port next state: accept, stream on handshake, abort wins over handshake.
    always_comb begin
      w_state_nxt = r_state;
      w_vreg_nxt  = r_vreg;
      w_len_nxt   = r_len;
      w_idx_nxt   = r_idx;
      w_data_nxt  = r_data;
      w_last_nxt  = r_last;
      case (r_state)
        ST_IDLE: begin
          if (!rd_abort[p] && req_valid[p]) begin
            w_vreg_nxt = w_req_vreg;
            w_len_nxt  = w_eff_len;
            w_idx_nxt  = '0;
            if (w_eff_len != '0) begin
              w_state_nxt = ST_STREAM;
              w_data_nxt  = w_ld_data;
              w_last_nxt  = (w_eff_len == LW'(1));
            end
          end
        end
        ST_STREAM: begin
          if (rd_abort[p]) begin
            w_state_nxt = ST_IDLE;
            w_last_nxt  = 1'b0;
          end else if (rd_ready[p]) begin
            if (r_last) begin
              w_state_nxt = ST_IDLE;
              w_last_nxt  = 1'b0;
            end else begin
              w_idx_nxt  = w_idx_inc[EW-1:0];
              w_data_nxt = w_ld_data;
              w_last_nxt = (w_idx_inc == (r_len - LW'(1)));
            end
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_last_nxt  = 1'b0;
        end
      endcase
    end

    // Read-port state registers.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_state <= ST_IDLE;
        r_vreg  <= '0;
        r_len   <= '0;
        r_idx   <= '0;
        r_data  <= '0;
        r_last  <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_vreg  <= w_vreg_nxt;
        r_len   <= w_len_nxt;
        r_idx   <= w_idx_nxt;
        r_data  <= w_data_nxt;
        r_last  <= w_last_nxt;
      end
    end

    assign req_ready[p]                                  = (r_state == ST_IDLE);
    assign rd_valid[p]                                   = (r_state == ST_STREAM);
    assign rd_last[p]                                    = r_last;
    assign rd_data[p*VECTOR_REG_WIDTH +: VECTOR_REG_WIDTH] = r_data;
  end

endmodule

// File: tb/tb_vector_register_bank.sv
// Directed bench for vector_register_bank with default parameters.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Each scenario task checks its own expected values inline.
module tb_vector_register_bank;

  localparam int NP = 2;
  localparam int W  = 64;
  localparam int RW = 3;
  localparam int EW = 6;
  localparam int LW = 7;
  localparam int BW = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_en;
  logic [RW-1:0]     wr_vreg;
  logic [EW-1:0]     wr_elem;
  logic [W-1:0]      wr_data;
  logic [BW-1:0]     wr_be;
  logic [NP-1:0]     req_valid;
  logic [NP-1:0]     req_ready;
  logic [NP*RW-1:0]  req_vreg;
  logic [NP*LW-1:0]  req_len;
  logic [NP-1:0]     rd_valid;
  logic [NP-1:0]     rd_ready;
  logic [NP*W-1:0]   rd_data;
  logic [NP-1:0]     rd_last;
  logic [NP-1:0]     rd_abort;

  int total = 0;
  int bad   = 0;

  vector_register_bank dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_vreg   (wr_vreg),
    .wr_elem   (wr_elem),
    .wr_data   (wr_data),
    .wr_be     (wr_be),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_vreg  (req_vreg),
    .req_len   (req_len),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_last   (rd_last),
    .rd_abort  (rd_abort)
  );

  always #5 clk = ~clk;

  task automatic wr(input int v, input int e, input logic [W-1:0] d, input logic [BW-1:0] be);
    wr_en   = 1'b1;
    wr_vreg = RW'(v);
    wr_elem = EW'(e);
    wr_data = d;
    wr_be   = be;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic req(input int p, input int v, input int l);
    req_valid[p]          = 1'b1;
    req_vreg[p*RW +: RW]  = RW'(v);
    req_len[p*LW +: LW]   = LW'(l);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (req_ready !== 2'b11) begin bad++; $display("FAIL reset_req_ready: got %b want 11", req_ready); end
    total++; if (rd_valid !== 2'b00) begin bad++; $display("FAIL reset_rd_valid: got %b want 00", rd_valid); end
    total++; if (rd_last !== 2'b00) begin bad++; $display("FAIL reset_rd_last: got %b want 00", rd_last); end
    total++; if (rd_data !== '0) begin bad++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    rd_ready = 2'b11;
    req(0, 3, 4);
    @(negedge clk);
    req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      total++; if ({rd_valid[0], rd_last[0], req_ready[0]} !== {1'b1, (i == 3), 1'b0}) begin
        bad++; $display("FAIL basic_ctrl beat %0d: valid/last/req_ready got %b%b%b want 1%b0",
                        i, rd_valid[0], rd_last[0], req_ready[0], (i == 3));
      end
      total++; if (rd_data[W-1:0] !== 64'h0) begin
        bad++; $display("FAIL basic_data beat %0d: got %h want 0", i, rd_data[W-1:0]);
      end
      @(negedge clk);
    end
    total++; if ({rd_valid[0], req_ready[0]} !== 2'b01) begin
      bad++; $display("FAIL basic_return_idle: valid/req_ready got %b%b want 01", rd_valid[0], req_ready[0]);
    end
  endtask

  task automatic test_stall();
    int beat;
    int cyc;
    for (int i = 0; i < 8; i++) wr(2, i, 64'h100 + 64'(i), 8'hFF);
    req(1, 2, 8);
    @(negedge clk);
    req_valid = '0;
    beat = 0;
    cyc  = 0;
    while (beat < 8 && cyc < 40) begin
      total++;
      if (rd_valid[1] !== 1'b1) begin
        bad++; $display("FAIL stall_valid cycle %0d: got %b want 1", cyc, rd_valid[1]);
      end else begin
        total++; if (rd_data[W +: W] !== 64'h100 + 64'(beat)) begin
          bad++; $display("FAIL stall_data beat %0d: got %h want %h", beat, rd_data[W +: W], 64'h100 + 64'(beat));
        end
        total++; if (rd_last[1] !== (beat == 7)) begin
          bad++; $display("FAIL stall_last beat %0d: got %b want %b", beat, rd_last[1], (beat == 7));
        end
      end
      rd_ready[1] = (cyc % 2 == 0);
      // While stalled, overwrite the element already held: the output must not change.
      if (!rd_ready[1]) begin
        wr_en = 1'b1; wr_vreg = 3'd2; wr_elem = EW'(beat); wr_data = 64'hDEAD; wr_be = 8'hFF;
      end else begin
        wr_en = 1'b0;
      end
      if (rd_valid[1] && rd_ready[1]) beat++;
      cyc++;
      @(negedge clk);
    end
    wr_en = 1'b0;
    rd_ready[1] = 1'b1;
    total++; if (beat !== 8) begin bad++; $display("FAIL stall_beat_count: got %0d want 8", beat); end
    total++; if ({rd_valid[1], req_ready[1]} !== 2'b01) begin
      bad++; $display("FAIL stall_end_idle: valid/req_ready got %b%b want 01", rd_valid[1], req_ready[1]);
    end
  endtask

  task automatic test_byte_enable();
    logic [W-1:0] exp;
    wr(1, 5, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    wr(1, 5, 64'h0, 8'h0F);
    wr(1, 5, 64'h1234, 8'h00);
    req(0, 1, 6);
    @(negedge clk);
    req_valid = '0;
    for (int i = 0; i < 6; i++) begin
      exp = (i == 5) ? 64'hFFFF_FFFF_0000_0000 : 64'h0;
      total++; if ({rd_valid[0], rd_last[0]} !== {1'b1, (i == 5)}) begin
        bad++; $display("FAIL be_ctrl beat %0d: valid/last got %b%b want 1%b", i, rd_valid[0], rd_last[0], (i == 5));
      end
      total++; if (rd_data[W-1:0] !== exp) begin
        bad++; $display("FAIL be_data elem %0d: got %h want %h", i, rd_data[W-1:0], exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_chain();
    rd_ready[0] = 1'b1;
    req(0, 4, 4);
    wr_en = 1'b1; wr_vreg = 3'd4; wr_elem = 6'd0; wr_data = 64'hA0; wr_be = 8'hFF;
    @(negedge clk);
    req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      total++; if ({rd_valid[0], rd_last[0]} !== {1'b1, (i == 3)}) begin
        bad++; $display("FAIL chain_ctrl beat %0d: valid/last got %b%b want 1%b", i, rd_valid[0], rd_last[0], (i == 3));
      end
      total++; if (rd_data[W-1:0] !== 64'hA0 + 64'(i)) begin
        bad++; $display("FAIL chain_data beat %0d: got %h want %h", i, rd_data[W-1:0], 64'hA0 + 64'(i));
      end
      if (i < 3) begin
        wr_elem = EW'(i + 1);
        wr_data = 64'hA0 + 64'(i + 1);
      end else begin
        wr_en = 1'b0;
      end
      @(negedge clk);
    end
    total++; if ({rd_valid[0], req_ready[0]} !== 2'b01) begin
      bad++; $display("FAIL chain_end_idle: valid/req_ready got %b%b want 01", rd_valid[0], req_ready[0]);
    end
  endtask

  task automatic test_len_edge();
    int beats;
    int cyc;
    req(0, 3, 0);
    @(negedge clk);
    req_valid = '0;
    for (int i = 0; i < 2; i++) begin
      total++; if ({rd_valid[0], req_ready[0]} !== 2'b01) begin
        bad++; $display("FAIL len0_idle cycle %0d: valid/req_ready got %b%b want 01", i, rd_valid[0], req_ready[0]);
      end
      @(negedge clk);
    end
    wr(5, 63, 64'h63, 8'hFF);
    req(0, 5, 100);
    @(negedge clk);
    req_valid = '0;
    beats = 0;
    cyc   = 0;
    while (rd_valid[0] === 1'b1 && cyc < 200) begin
      total++; if (rd_last[0] !== (beats == 63)) begin
        bad++; $display("FAIL clamp_last beat %0d: got %b want %b", beats, rd_last[0], (beats == 63));
      end
      if (beats == 63) begin
        total++; if (rd_data[W-1:0] !== 64'h63) begin
          bad++; $display("FAIL clamp_elem63: got %h want 63", rd_data[W-1:0]);
        end
      end
      beats++;
      cyc++;
      @(negedge clk);
    end
    total++; if (beats !== 64) begin bad++; $display("FAIL clamp_beat_count: got %0d want 64", beats); end
  endtask

  task automatic test_abort();
    for (int i = 0; i < 10; i++) wr(6, i, 64'h600 + 64'(i), 8'hFF);
    rd_ready = 2'b11;
    req(0, 6, 10);
    req(1, 6, 10);
    @(negedge clk);
    req_valid = '0;
    for (int k = 0; k < 10; k++) begin
      total++; if ({rd_valid[1], rd_last[1]} !== {1'b1, (k == 9)}) begin
        bad++; $display("FAIL abort_p1_ctrl beat %0d: valid/last got %b%b want 1%b", k, rd_valid[1], rd_last[1], (k == 9));
      end
      total++; if (rd_data[W +: W] !== 64'h600 + 64'(k)) begin
        bad++; $display("FAIL abort_p1_data beat %0d: got %h want %h", k, rd_data[W +: W], 64'h600 + 64'(k));
      end
      if (k <= 3) begin
        total++; if (rd_valid[0] !== 1'b1 || rd_data[W-1:0] !== 64'h600 + 64'(k)) begin
          bad++; $display("FAIL abort_p0_beat %0d: valid %b data %h want 1 %h", k, rd_valid[0], rd_data[W-1:0], 64'h600 + 64'(k));
        end
      end else begin
        total++; if ({rd_valid[0], req_ready[0]} !== 2'b01) begin
          bad++; $display("FAIL abort_p0_idle cycle %0d: valid/req_ready got %b%b want 01", k, rd_valid[0], req_ready[0]);
        end
      end
      rd_abort[0] = (k == 3);
      @(negedge clk);
    end
    rd_abort = '0;
    total++; if ({rd_valid, req_ready} !== 4'b0011) begin
      bad++; $display("FAIL abort_end_idle: valid %b req_ready %b want 00 11", rd_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid();
    wr(7, 0, 64'h777, 8'hFF);
    rd_ready = 2'b11;
    req(0, 7, 10);
    req(1, 7, 10);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    total++; if (rd_valid !== 2'b11) begin bad++; $display("FAIL rstmid_pre_valid: got %b want 11", rd_valid); end
    reset = 1'b1;
    @(negedge clk);
    total++; if (rd_valid !== 2'b00) begin bad++; $display("FAIL rstmid_valid: got %b want 00", rd_valid); end
    total++; if (req_ready !== 2'b11) begin bad++; $display("FAIL rstmid_req_ready: got %b want 11", req_ready); end
    total++; if (rd_data !== '0 || rd_last !== 2'b00) begin
      bad++; $display("FAIL rstmid_data_last: data %h last %b want 0 00", rd_data, rd_last);
    end
    reset = 1'b0;
    @(negedge clk);
    total++; if (rd_valid !== 2'b00) begin bad++; $display("FAIL rstmid_no_resume: got %b want 00", rd_valid); end
    req(0, 7, 2);
    @(negedge clk);
    req_valid = '0;
    for (int i = 0; i < 2; i++) begin
      total++; if (rd_valid[0] !== 1'b1 || rd_data[W-1:0] !== 64'h0) begin
        bad++; $display("FAIL rstmid_mem_cleared elem %0d: valid %b data %h want 1 0", i, rd_valid[0], rd_data[W-1:0]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    reset     = 1'b1;
    wr_en     = 1'b0;
    wr_vreg   = '0;
    wr_elem   = '0;
    wr_data   = '0;
    wr_be     = '0;
    req_valid = '0;
    req_vreg  = '0;
    req_len   = '0;
    rd_ready  = '0;
    rd_abort  = '0;
    test_reset();
    test_basic();
    test_stall();
    test_byte_enable();
    test_chain();
    test_len_edge();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
